// File: rtl/decode_cycle.sv
// Decode stage: aligns fetch PCs with the one-cycle-late instruction word, holds the
// IF/ID register, decodes fields/controls, and stalls fetch on load-use hazards.
//
// state   | meaning
// RUN     | normal issue; pcwrite follows the hazard check
// HALTED  | HALT issued; fetch frozen, bubbles until reset
module decode_cycle #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ir,
    input  logic [W-1:0] currpc,
    input  logic [W-1:0] newpc,
    input  logic         flush,
    output logic         pcwrite,
    output logic         id_valid,
    output logic [W-1:0] id_pc,
    output logic [W-1:0] id_newpc,
    output logic [3:0]   id_opcode,
    output logic [3:0]   id_rd,
    output logic [3:0]   id_rs,
    output logic [3:0]   id_rt,
    output logic [W-1:0] id_imm,
    output logic         id_regwrite,
    output logic         id_memread,
    output logic         id_memwrite,
    output logic         id_branch,
    output logic         id_jump,
    output logic         id_halt
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] pc;
        logic [W-1:0] npc;
        logic [3:0]   opcode;
        logic [3:0]   rd;
        logic [3:0]   rs;
        logic [3:0]   rt;
        logic [W-1:0] imm;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
        logic         branch;
        logic         jump;
        logic         halt;
    } id_t;

    state_e       state_q, state_d;
    logic [W-1:0] align_pc_q, align_pc_d;
    logic [W-1:0] align_npc_q, align_npc_d;
    logic         align_v_q, align_v_d;
    id_t          id_q, id_d;
    id_t          dec;

    logic         use_rd, use_rs, use_rt;
    logic         hit;
    logic         stall;

    always_comb begin
        dec        = '0;
        use_rd     = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        dec.valid  = align_v_q;
        dec.pc     = align_pc_q;
        dec.npc    = align_npc_q;
        dec.opcode = ir[15:12];
        dec.rd     = ir[11:8];
        dec.rs     = ir[7:4];
        dec.rt     = ir[3:0];
        case (ir[15:12])
            4'h0, 4'h1, 4'h2, 4'h3: begin
                use_rs       = 1'b1;
                use_rt       = 1'b1;
                dec.regwrite = 1'b1;
            end
            4'h4: begin
                use_rs       = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = {{(W-4){ir[3]}}, ir[3:0]};
            end
            4'h5: begin
                dec.regwrite = 1'b1;
                dec.imm      = W'({ir[7:0], 8'h00});
            end
            4'h6: begin
                use_rs       = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.imm      = {{(W-4){ir[3]}}, ir[3:0]};
            end
            4'h7: begin
                use_rs       = 1'b1;
                use_rd       = 1'b1;
                dec.memwrite = 1'b1;
                dec.imm      = {{(W-4){ir[3]}}, ir[3:0]};
            end
            4'h8, 4'h9: begin
                use_rd     = 1'b1;
                use_rs     = 1'b1;
                dec.branch = 1'b1;
                dec.imm    = {{(W-5){ir[3]}}, ir[3:0], 1'b0};
            end
            4'hA: begin
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
                dec.imm      = {{(W-9){ir[7]}}, ir[7:0], 1'b0};
            end
            4'hB: begin
                use_rs   = 1'b1;
                dec.jump = 1'b1;
            end
            4'hF: dec.halt = 1'b1;
            default: ;
        endcase
        if (ir[11:8] == 4'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    // id_rd != 0 already excludes r0, so a read of r0 can never match.
    assign hit   = (use_rs && ir[7:4]  == id_q.rd) ||
                   (use_rt && ir[3:0]  == id_q.rd) ||
                   (use_rd && ir[11:8] == id_q.rd);
    assign stall = id_q.valid && id_q.memread && (id_q.rd != 4'd0) &&
                   align_v_q && !flush && hit;

    assign pcwrite = (state_q == ST_RUN) && !stall && rst;

    always_comb begin
        state_d     = state_q;
        align_pc_d  = align_pc_q;
        align_npc_d = align_npc_q;
        align_v_d   = align_v_q;
        id_d        = '0;
        if (pcwrite) begin
            align_pc_d  = currpc;
            align_npc_d = newpc;
            align_v_d   = 1'b1;
        end
        if (flush) begin
            align_v_d = 1'b0;
        end
        if (!flush && !stall && state_q == ST_RUN) begin
            id_d = dec;
            if (align_v_q && dec.halt) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            align_pc_q  <= '0;
            align_npc_q <= '0;
            align_v_q   <= 1'b0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            align_pc_q  <= align_pc_d;
            align_npc_q <= align_npc_d;
            align_v_q   <= align_v_d;
            id_q        <= id_d;
        end
    end

    assign id_valid    = id_q.valid;
    assign id_pc       = id_q.pc;
    assign id_newpc    = id_q.npc;
    assign id_opcode   = id_q.opcode;
    assign id_rd       = id_q.rd;
    assign id_rs       = id_q.rs;
    assign id_rt       = id_q.rt;
    assign id_imm      = id_q.imm;
    assign id_regwrite = id_q.regwrite;
    assign id_memread  = id_q.memread;
    assign id_memwrite = id_q.memwrite;
    assign id_branch   = id_q.branch;
    assign id_jump     = id_q.jump;
    assign id_halt     = id_q.halt;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle; a tiny fetch/imem model whose read and PC advance
// are both gated by pcwrite, so a stalled word stays on ir.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [15:0] ir, currpc, newpc;
    logic        flush;
    logic        pcwrite, id_valid;
    logic [15:0] id_pc, id_newpc, id_imm;
    logic [3:0]  id_opcode, id_rd, id_rs, id_rt;
    logic        id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_halt;

    logic [15:0] imem [32];
    int n_checks = 0;
    int n_fail   = 0;

    decode_cycle #(.W(16)) dut (
        .clk(clk), .rst(rst), .ir(ir), .currpc(currpc), .newpc(newpc), .flush(flush),
        .pcwrite(pcwrite), .id_valid(id_valid), .id_pc(id_pc), .id_newpc(id_newpc),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jump(id_jump), .id_halt(id_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_prog(input logic [15:0] a, b, c, d, e);
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
        imem[0] = a; imem[1] = b; imem[2] = c; imem[3] = d; imem[4] = e;
    endtask

    // Leaves rst low for one edge, releases it 2 time units after that edge.
    task automatic do_reset();
        rst = 1'b0; flush = 1'b0;
        currpc = 16'h0000; newpc = 16'h0002; ir = 16'h0000;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    // One clock; returns at posedge+2 with fetch model updated.
    task automatic cycle();
        logic pw;
        @(negedge clk);
        pw = pcwrite;
        @(posedge clk); #1;
        if (pw) begin
            ir     = imem[currpc[5:1]];
            currpc = currpc + 16'd2;
            newpc  = currpc + 16'd2;
        end
        #1;
    endtask

    task automatic test_reset();
        load_prog(16'h4215, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        rst = 1'b0; flush = 1'b0; currpc = 0; newpc = 2; ir = 0;
        #1;
        n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pcwrite: got %b want 0", pcwrite); end
        n_checks++; if ({id_valid, id_pc, id_imm, id_regwrite} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs: valid=%b pc=%h imm=%h", id_valid, id_pc, id_imm); end
        @(posedge clk); #2; rst = 1'b1; #1;
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL release_pcwrite: got %b want 1", pcwrite); end
        cycle();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL first_cycle_valid: got %b want 0", id_valid); end
        cycle();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_newpc !== 16'h0002) begin n_fail++; $display("FAIL addi_pcs: valid=%b pc=%h npc=%h want 1/0000/0002", id_valid, id_pc, id_newpc); end
        n_checks++; if (id_rd !== 4'd2 || id_rs !== 4'd1 || id_imm !== 16'h0005 || id_regwrite !== 1'b1) begin n_fail++; $display("FAIL addi_fields: rd=%h rs=%h imm=%h rw=%b want 2/1/0005/1", id_rd, id_rs, id_imm, id_regwrite); end
    endtask

    task automatic test_immediates();
        load_prog(16'h431C, 16'h912E, 16'hA1FF, 16'h5312, 16'h7215);
        do_reset();
        cycle(); cycle();
        n_checks++; if (id_imm !== 16'hFFFC || id_opcode !== 4'h4 || id_regwrite !== 1'b1) begin n_fail++; $display("FAIL addi_neg: imm=%h op=%h rw=%b want FFFC/4/1", id_imm, id_opcode, id_regwrite); end
        cycle();
        n_checks++; if (id_imm !== 16'hFFFC || id_branch !== 1'b1 || id_regwrite !== 1'b0 || id_pc !== 16'h0002) begin n_fail++; $display("FAIL bne: imm=%h br=%b rw=%b pc=%h want FFFC/1/0/0002", id_imm, id_branch, id_regwrite, id_pc); end
        cycle();
        n_checks++; if (id_imm !== 16'hFFFE || id_jump !== 1'b1 || id_regwrite !== 1'b1) begin n_fail++; $display("FAIL jal: imm=%h jump=%b rw=%b want FFFE/1/1", id_imm, id_jump, id_regwrite); end
        cycle();
        n_checks++; if (id_imm !== 16'h1200 || id_rd !== 4'd3 || id_jump !== 1'b0) begin n_fail++; $display("FAIL lui: imm=%h rd=%h jump=%b want 1200/3/0", id_imm, id_rd, id_jump); end
        cycle();
        n_checks++; if (id_memwrite !== 1'b1 || id_regwrite !== 1'b0 || id_imm !== 16'h0005) begin n_fail++; $display("FAIL sw: mw=%b rw=%b imm=%h want 1/0/0005", id_memwrite, id_regwrite, id_imm); end
    endtask

    task automatic test_load_use();
        load_prog(16'h6215, 16'h0324, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        cycle(); cycle();
        n_checks++; if (id_memread !== 1'b1 || id_rd !== 4'd2) begin n_fail++; $display("FAIL lw_issue: mr=%b rd=%h want 1/2", id_memread, id_rd); end
        n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL stall_pcwrite: got %b want 0", pcwrite); end
        cycle();
        n_checks++; if (id_valid !== 1'b0 || pcwrite !== 1'b1) begin n_fail++; $display("FAIL stall_bubble: valid=%b pcwrite=%b want 0/1", id_valid, pcwrite); end
        cycle();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0002 || id_rd !== 4'd3 || id_opcode !== 4'h0) begin n_fail++; $display("FAIL add_after_stall: valid=%b pc=%h rd=%h op=%h want 1/0002/3/0", id_valid, id_pc, id_rd, id_opcode); end
        load_prog(16'h6015, 16'h0324, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        cycle(); cycle();
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL r0_no_stall: pcwrite=%b want 1", pcwrite); end
        cycle();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0002) begin n_fail++; $display("FAIL r0_add_issue: valid=%b pc=%h want 1/0002", id_valid, id_pc); end
    endtask

    task automatic test_flush();
        load_prog(16'h6215, 16'h0324, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        cycle(); cycle();
        flush = 1'b1; #1;
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL flush_beats_stall: pcwrite=%b want 1", pcwrite); end
        cycle();
        flush = 1'b0; #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bubble1: valid=%b want 0", id_valid); end
        cycle();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bubble2: valid=%b want 0", id_valid); end
        cycle();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0006) begin n_fail++; $display("FAIL flush_resume: valid=%b pc=%h want 1/0006", id_valid, id_pc); end
    endtask

    task automatic test_halt();
        load_prog(16'h4215, 16'hF000, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        cycle(); cycle(); cycle();
        n_checks++; if (id_valid !== 1'b1 || id_halt !== 1'b1 || id_pc !== 16'h0002) begin n_fail++; $display("FAIL halt_issue: valid=%b halt=%b pc=%h want 1/1/0002", id_valid, id_halt, id_pc); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL halted_pcwrite[%0d]: got %b want 0", i, pcwrite); end
            cycle();
            n_checks++; if (id_valid !== 1'b0 || id_halt !== 1'b0) begin n_fail++; $display("FAIL halted_bubble[%0d]: valid=%b halt=%b want 0/0", i, id_valid, id_halt); end
        end
        rst = 1'b0; #1;
        n_checks++; if (id_valid !== 1'b0 || id_pc !== 16'h0000 || pcwrite !== 1'b0) begin n_fail++; $display("FAIL async_reset: valid=%b pc=%h pcwrite=%b want 0/0000/0", id_valid, id_pc, pcwrite); end
        do_reset();
        #1;
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL resume_pcwrite: got %b want 1", pcwrite); end
        cycle(); cycle();
        n_checks++; if (id_valid !== 1'b1 || id_opcode !== 4'h4 || id_pc !== 16'h0000) begin n_fail++; $display("FAIL resume_issue: valid=%b op=%h pc=%h want 1/4/0000", id_valid, id_opcode, id_pc); end
    endtask

    task automatic test_halt_flush();
        load_prog(16'h4215, 16'hF000, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        cycle(); cycle();
        flush = 1'b1; #1;
        n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL halt_flush_pcwrite: got %b want 1", pcwrite); end
        cycle();
        flush = 1'b0; #1;
        n_checks++; if (pcwrite !== 1'b1 || id_halt !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL squashed_halt: pcwrite=%b halt=%b valid=%b want 1/0/0", pcwrite, id_halt, id_valid); end
        cycle(); cycle();
        n_checks++; if (pcwrite !== 1'b1 || id_valid !== 1'b1 || id_halt !== 1'b0) begin n_fail++; $display("FAIL after_squash: pcwrite=%b valid=%b halt=%b want 1/1/0", pcwrite, id_valid, id_halt); end
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_load_use();
        test_flush();
        test_halt();
        test_halt_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
